// File: rtl/cache_arbiter_if.sv
// Cache-side and memory-side line transfer signals for the I/D cache arbiter.
// The slave modport is the arbiter's view; master is the cache/memory environment.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache,
// one line transaction at a time, alternating grants under contention.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_grant_d;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;
  logic                  lat_write;
  logic                  pend_i;
  logic                  pend_d;
  logic                  grant_i;
  logic                  grant_d;

  assign pend_i  = bus.i_read;
  assign pend_d  = bus.d_read | bus.d_write;
  // Under contention the side that did not win last time takes the grant.
  assign grant_d = (state == IDLE) & pend_d & (~pend_i | ~last_grant_d);
  assign grant_i = (state == IDLE) & pend_i & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_write    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        last_grant_d <= 1'b1;
        lat_addr     <= bus.d_address;
        lat_write    <= bus.d_write;
        if (bus.d_write) lat_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        last_grant_d <= 1'b0;
        lat_addr     <= bus.i_address;
        lat_write    <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = SERVE_D;
        else if (grant_i) state_nxt = SERVE_I;
      end
      SERVE_I: begin
        bus.pmem_read = 1'b1;
        bus.i_resp    = bus.pmem_resp;
        if (bus.pmem_resp) state_nxt = IDLE;
      end
      SERVE_D: begin
        bus.pmem_read  = ~lat_write;
        bus.pmem_write = lat_write;
        bus.d_resp     = bus.pmem_resp;
        if (bus.pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A transaction being abandoned by reset must not strobe memory or requesters.
    if (rst) begin
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      bus.i_resp     = 1'b0;
      bus.d_resp     = 1'b0;
    end
  end

  assign bus.pmem_address = lat_addr;
  assign bus.pmem_wdata   = lat_wdata;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

  // Simultaneous read and write from the D-cache is illegal; the write wins.
  a_d_rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(grant_d && bus.d_read && bus.d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: per-cycle vector table, directed multi-cycle
// sequences, and randomized traffic against a transaction-level model.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [3:0] strb();
    return {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp};
  endfunction

  task automatic clear_inputs();
    bus.i_read = 0; bus.d_read = 0; bus.d_write = 0; bus.pmem_resp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); rst = 0;
  endtask

  // strb = {pmem_read, pmem_write, i_resp, d_resp}
  typedef struct {
    logic        rst, ir, dr, dw, presp;
    logic [3:0]  exp_strb;
    logic        chk_addr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[20];

  // Random-phase model state
  bit             m_busy, m_own_d, m_wr, m_last_d, i_act, d_act, d_wr, g_d;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_wdata, wd_a5;
  logic [3:0]     m_strb;
  int             lat, seen;
  string          order;

  initial begin
    rst = 1; clear_inputs();
    bus.i_address = 32'h200; bus.d_address = 32'h100;
    bus.d_wdata = '0; bus.pmem_rdata = {8{32'h1234_5678}};

    tbl[0]  = '{1,0,0,0,0, 4'b0000, 0, 32'h0};
    tbl[1]  = '{1,0,0,0,0, 4'b0000, 1, 32'h0};
    tbl[2]  = '{0,1,1,0,0, 4'b0000, 1, 32'h0};
    tbl[3]  = '{0,1,1,0,0, 4'b1000, 1, 32'h100};
    tbl[4]  = '{0,1,1,0,0, 4'b1000, 1, 32'h100};
    tbl[5]  = '{0,1,1,0,1, 4'b1001, 1, 32'h100};
    tbl[6]  = '{0,1,0,0,0, 4'b0000, 1, 32'h100};
    tbl[7]  = '{0,1,0,0,0, 4'b1000, 1, 32'h200};
    tbl[8]  = '{0,1,0,0,1, 4'b1010, 1, 32'h200};
    tbl[9]  = '{0,0,0,0,1, 4'b0000, 1, 32'h200};
    tbl[10] = '{0,0,0,0,0, 4'b0000, 1, 32'h200};
    tbl[11] = '{0,0,1,0,0, 4'b0000, 1, 32'h200};
    tbl[12] = '{0,0,1,0,0, 4'b1000, 1, 32'h100};
    tbl[13] = '{1,0,1,0,0, 4'b0000, 1, 32'h100};
    tbl[14] = '{0,0,0,0,0, 4'b0000, 1, 32'h0};
    tbl[15] = '{0,0,0,0,1, 4'b0000, 1, 32'h0};
    tbl[16] = '{0,1,1,0,0, 4'b0000, 1, 32'h0};
    tbl[17] = '{0,1,1,0,0, 4'b1000, 1, 32'h100};
    tbl[18] = '{0,0,1,0,1, 4'b1001, 1, 32'h100};
    tbl[19] = '{0,0,0,0,0, 4'b0000, 1, 32'h100};

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rst = tbl[k].rst; bus.i_read = tbl[k].ir; bus.d_read = tbl[k].dr;
      bus.d_write = tbl[k].dw; bus.pmem_resp = tbl[k].presp;
      #1;
      check($sformatf("tbl%0d_strb", k), strb(), tbl[k].exp_strb);
      if (tbl[k].chk_addr) check($sformatf("tbl%0d_addr", k), bus.pmem_address, tbl[k].exp_addr);
      if (bus.d_resp) check($sformatf("tbl%0d_drdata", k), bus.d_rdata, bus.pmem_rdata);
    end

    // Lone I-miss, memory answers 4 cycles after the read strobe appears
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h60; bus.pmem_resp = 0;
    bus.pmem_rdata = rand_line();
    #1; check("imiss_idle", strb(), 4'b0000);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk); bus.pmem_resp = (n == 5); #1;
      check($sformatf("imiss_c%0d_strb", n), strb(), (n == 5) ? 4'b1010 : 4'b1000);
      check($sformatf("imiss_c%0d_addr", n), bus.pmem_address, 32'h60);
      if (n == 5) check("imiss_rdata", bus.i_rdata, bus.pmem_rdata);
    end
    @(negedge clk); bus.i_read = 0; bus.pmem_resp = 0; #1;
    check("imiss_back_idle", strb(), 4'b0000);

    // D writeback, d_wdata changes underneath the transaction
    wd_a5 = {32{8'hA5}};
    @(negedge clk);
    bus.d_write = 1; bus.d_address = 32'h8000_0040; bus.d_wdata = wd_a5; #1;
    check("wb_idle", strb(), 4'b0000);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 2) bus.d_wdata = '0;
      bus.pmem_resp = (n == 4); #1;
      check($sformatf("wb_c%0d_strb", n), strb(), (n == 4) ? 4'b0101 : 4'b0100);
      check($sformatf("wb_c%0d_wdata", n), bus.pmem_wdata, wd_a5);
      check($sformatf("wb_c%0d_addr", n), bus.pmem_address, 32'h8000_0040);
    end
    @(negedge clk); bus.d_write = 0; bus.pmem_resp = 0; #1;
    check("wb_back_idle", strb(), 4'b0000);

    // Sustained contention: both re-request immediately, memory latency 1
    do_reset();
    bus.d_address = 32'h100; bus.i_address = 32'h200;
    seen = 0; order = "";
    for (int c = 0; c < 80 && order.len() < 6; c++) begin
      @(negedge clk);
      bus.i_read = 1; bus.d_read = 1; bus.pmem_resp = (seen >= 1); #1;
      if (bus.d_resp) order = {order, "D"};
      if (bus.i_resp) order = {order, "I"};
      if (bus.pmem_resp) seen = 0;
      else if (bus.pmem_read) seen++;
      else seen = 0;
    end
    checks++;
    if (order != "DIDIDI") begin
      failures++;
      $display("FAIL contention_order actual=%s required=DIDIDI", order);
    end
    @(negedge clk); clear_inputs();
    @(negedge clk);

    // Randomized traffic against the transaction model
    do_reset();
    m_busy = 0; m_last_d = 0; i_act = 0; d_act = 0; d_wr = 0; lat = 0;
    m_own_d = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!i_act && $urandom_range(2) == 0) begin
        i_act = 1; bus.i_address = $urandom & 32'hFFFF_FFE0;
      end
      if (!d_act && $urandom_range(2) == 0) begin
        d_act = 1; d_wr = $urandom_range(1);
        bus.d_address = $urandom & 32'hFFFF_FFE0; bus.d_wdata = rand_line();
      end
      if (m_busy && m_own_d)  bus.d_wdata   = rand_line();
      if (m_busy && !m_own_d) bus.i_address = $urandom;
      bus.i_read  = i_act;
      bus.d_read  = d_act & ~d_wr;
      bus.d_write = d_act & d_wr;
      bus.pmem_rdata = rand_line();
      bus.pmem_resp  = m_busy ? (lat == 0) : ($urandom_range(7) == 0);
      #1;
      m_strb = m_busy ? {(!m_own_d || !m_wr), (m_own_d && m_wr),
                         (!m_own_d && bus.pmem_resp), (m_own_d && bus.pmem_resp)} : 4'b0000;
      check($sformatf("rnd%0d_strb", c), strb(), m_strb);
      if (m_busy) check($sformatf("rnd%0d_addr", c), bus.pmem_address, m_addr);
      if (m_busy && m_wr) check($sformatf("rnd%0d_wdata", c), bus.pmem_wdata, m_wdata);
      if (bus.i_resp) check($sformatf("rnd%0d_irdata", c), bus.i_rdata, bus.pmem_rdata);
      if (bus.d_resp) check($sformatf("rnd%0d_drdata", c), bus.d_rdata, bus.pmem_rdata);
      // what happens at the coming clock edge
      if (m_busy) begin
        if (bus.pmem_resp) begin
          m_busy = 0;
          if (m_own_d) d_act = 0; else i_act = 0;
        end else lat--;
      end else if (i_act || d_act) begin
        g_d      = d_act && (!i_act || !m_last_d);
        m_own_d  = g_d;
        m_last_d = g_d;
        m_wr     = g_d && d_wr;
        m_addr   = g_d ? bus.d_address : bus.i_address;
        if (m_wr) m_wdata = bus.d_wdata;
        lat      = $urandom_range(4);
        m_busy   = 1;
      end
    end

    @(negedge clk); clear_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
